// File: rtl/ldpc_pkg.sv
// Shared LDPC encoder-side definitions: byte width, default codeword geometry and the
// feeder FSM state encoding.
package ldpc_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned MSG_BYTES_DEF = 128;
    localparam int unsigned PAR_BYTES_DEF = 128;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StMsg,
        StWait,
        StRead,
        StPar,
        StDrain
    } feed_state_e;

endpackage

// File: rtl/ldpc_enc_feeder_if.sv
// Bundle of the feeder's upstream stream, encoder control/data and downstream stream.
// master = feeder side, slave = the surrounding source, encoder and sink.
interface ldpc_enc_feeder_if;
    import ldpc_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;

    logic              enc_en_start;
    logic              enc_en_din;
    logic [BYTE_W-1:0] enc_d_in;
    logic              enc_read_parity;
    logic              enc_done_encode;
    logic              enc_en_out;
    logic [BYTE_W-1:0] enc_d_out;

    logic              m_valid;
    logic              m_ready;
    logic [BYTE_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  s_valid, s_data, enc_done_encode, enc_en_out, enc_d_out, m_ready,
        output s_ready, enc_en_start, enc_en_din, enc_d_in, enc_read_parity,
               m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, enc_done_encode, enc_en_out, enc_d_out, m_ready,
        input  s_ready, enc_en_start, enc_en_din, enc_d_in, enc_read_parity,
               m_valid, m_data, m_last
    );

endinterface

// File: rtl/ldpc_par_fifo.sv
// Synchronous FIFO buffering encoder parity bytes; the caller guarantees no push when full
// and no pop when empty.
module ldpc_par_fifo #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    // Wrap explicitly so non-power-of-two depths stay correct.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;

endmodule

// File: rtl/ldpc_enc_feeder.sv
// Feeds message bytes to an LDPC encoder while forwarding them, then streams back the parity.
// Optional WAIT timeout with sticky err_timeout when LDPC_FEED_TIMEOUT_EN is defined.
module ldpc_enc_feeder
    import ldpc_pkg::*;
#(
    parameter int unsigned MSG_BYTES = MSG_BYTES_DEF,
    parameter int unsigned PAR_BYTES = PAR_BYTES_DEF,
    parameter int unsigned TMO_CYC   = 4096
) (
    input  logic clk,
    input  logic rst_n,
    ldpc_enc_feeder_if.master bus,
`ifdef LDPC_FEED_TIMEOUT_EN
    output logic err_timeout,
`endif
    output logic busy
);

    localparam int unsigned MW  = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int unsigned PW  = (PAR_BYTES > 1) ? $clog2(PAR_BYTES) : 1;
    localparam int unsigned FCW = $clog2(PAR_BYTES + 1);

    feed_state_e state_q, state_d;
    logic [MW-1:0] msg_cnt_q;
    logic [PW-1:0] par_cnt_q;

    logic accept, msg_last, push, par_last, pop, drain_last, tmo_hit;

    logic              fifo_empty;
    logic              fifo_full;
    logic [BYTE_W-1:0] fifo_rdata;
    logic [FCW-1:0]    fifo_count;

    logic              drv_s_ready;
    logic              drv_en_start;
    logic              drv_en_din;
    logic [BYTE_W-1:0] drv_d_in;
    logic              drv_read_parity;
    logic              drv_m_valid;
    logic [BYTE_W-1:0] drv_m_data;
    logic              drv_m_last;

    assign accept     = (state_q == StMsg) && bus.s_valid && bus.m_ready;
    assign msg_last   = accept && (msg_cnt_q == MW'(MSG_BYTES - 1));
    // Encoder has no backpressure; outside PAR its strobe is ignored.
    assign push       = (state_q == StPar) && bus.enc_en_out && !fifo_full;
    assign par_last   = push && (par_cnt_q == PW'(PAR_BYTES - 1));
    assign pop        = ((state_q == StPar) || (state_q == StDrain)) && !fifo_empty && bus.m_ready;
    assign drain_last = (state_q == StDrain) && pop && (fifo_count == FCW'(1));

`ifdef LDPC_FEED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;

    assign tmo_hit = (state_q == StWait) && !bus.enc_done_encode &&
                     (tmo_cnt_q == TW'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StWait) ? tmo_cnt_q + 1'b1 : '0;
            err_q     <= err_q | tmo_hit;
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            msg_cnt_q <= '0;
            par_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (msg_last)    msg_cnt_q <= '0;
            else if (accept) msg_cnt_q <= msg_cnt_q + 1'b1;
            if (par_last)    par_cnt_q <= '0;
            else if (push)   par_cnt_q <= par_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.s_valid) state_d = StStart;
            StStart: state_d = StMsg;
            StMsg:   if (msg_last) state_d = StWait;
            StWait: begin
                if (bus.enc_done_encode) state_d = StRead;
                else if (tmo_hit)        state_d = StIdle;
            end
            StRead:  state_d = StPar;
            StPar:   if (par_last) state_d = StDrain;
            StDrain: if (drain_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        drv_s_ready     = 1'b0;
        drv_en_start    = 1'b0;
        drv_en_din      = 1'b0;
        drv_d_in        = '0;
        drv_read_parity = 1'b0;
        drv_m_valid     = 1'b0;
        drv_m_data      = '0;
        drv_m_last      = 1'b0;
        unique case (state_q)
            StStart: drv_en_start = 1'b1;
            StMsg: begin
                drv_s_ready = bus.m_ready;
                drv_m_valid = bus.s_valid;
                drv_m_data  = bus.s_data;
                drv_en_din  = accept;
                drv_d_in    = accept ? bus.s_data : '0;
            end
            StRead:  drv_read_parity = 1'b1;
            StPar, StDrain: begin
                drv_m_valid = !fifo_empty;
                drv_m_data  = fifo_empty ? '0 : fifo_rdata;
                // Final parity byte is always popped in DRAIN with exactly one entry left.
                drv_m_last  = (state_q == StDrain) && (fifo_count == FCW'(1));
            end
            default: ;
        endcase
    end

    assign bus.s_ready         = drv_s_ready;
    assign bus.enc_en_start    = drv_en_start;
    assign bus.enc_en_din      = drv_en_din;
    assign bus.enc_d_in        = drv_d_in;
    assign bus.enc_read_parity = drv_read_parity;
    assign bus.m_valid         = drv_m_valid;
    assign bus.m_data          = drv_m_data;
    assign bus.m_last          = drv_m_last;
    assign busy                = (state_q != StIdle);

    ldpc_par_fifo #(
        .DEPTH (PAR_BYTES),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.enc_d_out),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ldpc_enc_feeder.sv
// Directed bench for ldpc_enc_feeder: full codewords under several m_ready patterns,
// mid-codeword reset, stray parity strobes and (with LDPC_FEED_TIMEOUT_EN) the WAIT timeout.
module tb_ldpc_enc_feeder;
    import ldpc_pkg::*;

    localparam int unsigned MB = 128;
    localparam int unsigned PB = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef LDPC_FEED_TIMEOUT_EN
    logic err_timeout;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] outq[$];
    int n_start = 0;
    int n_din = 0;
    int n_read = 0;
    int n_last = 0;
    int rdy_mode = 0;
    int cyc = 0;

    ldpc_enc_feeder_if bus();

    ldpc_enc_feeder #(
        .MSG_BYTES (MB),
        .PAR_BYTES (PB),
        .TMO_CYC   (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
`ifdef LDPC_FEED_TIMEOUT_EN
        .err_timeout (err_timeout),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream sink: m_ready pattern chosen by rdy_mode (0 always, 1 one-of-three, 2 stalled).
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = (cyc % 3 == 0);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            outq.push_back({bus.m_last, bus.m_data});
            if (bus.m_last) n_last++;
        end
        if (bus.enc_en_start)    n_start++;
        if (bus.enc_en_din)      n_din++;
        if (bus.enc_read_parity) n_read++;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},    32'(busy), 32'(0));
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'(0));
        check({tag, "_m_valid"}, 32'(bus.m_valid), 32'(0));
        check({tag, "_m_last"},  32'(bus.m_last), 32'(0));
        check({tag, "_m_data"},  32'(bus.m_data), 32'(0));
        check({tag, "_start"},   32'(bus.enc_en_start), 32'(0));
        check({tag, "_en_din"},  32'(bus.enc_en_din), 32'(0));
        check({tag, "_d_in"},    32'(bus.enc_d_in), 32'(0));
        check({tag, "_rdpar"},   32'(bus.enc_read_parity), 32'(0));
    endtask

    // Presents n bytes base, base+1, ...; once in MSG checks the pass-through handshake.
    task automatic send_msg(input int n, input logic [7:0] base);
        logic hs;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = base + 8'(i);
            hs = 1'b0;
            while (!hs) begin
                @(negedge clk);
                hs = bus.s_valid && bus.s_ready;
                if (i > 0) begin
                    check("s_ready_tracks", 32'(bus.s_ready), 32'(bus.m_ready));
                    check("en_din", 32'(bus.enc_en_din), 32'(bus.m_ready));
                    if (bus.m_ready) check("d_in", 32'(bus.enc_d_in), 32'(bus.s_data));
                end
                tick();
            end
        end
        bus.s_valid = 1'b0;
    endtask

    // Encoder model: done after a short delay, then PB parity bytes one per cycle after the read.
    task automatic encode(input logic [7:0] base);
        logic got;
        repeat (3) tick();
        bus.enc_en_out      = 1'b0;
        bus.enc_done_encode = 1'b1;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            got = bus.enc_read_parity;
            tick();
        end
        bus.enc_done_encode = 1'b0;
        for (int i = 0; i < PB; i++) begin
            bus.enc_en_out = 1'b1;
            bus.enc_d_out  = base + 8'(i);
            tick();
        end
        bus.enc_en_out = 1'b0;
    endtask

    task automatic wait_idle();
        while (busy) tick();
    endtask

    task automatic check_codeword(input int b, input logic [7:0] mb, input logic [7:0] pb);
        logic [8:0] e;
        check("cw_len", 32'(outq.size() - b), 32'(MB + PB));
        for (int i = 0; i < MB + PB && b + i < outq.size(); i++) begin
            e[7:0] = (i < MB) ? mb + 8'(i) : pb + 8'(i - MB);
            e[8]   = (i == MB + PB - 1);
            check($sformatf("cw_byte[%0d]", i), 32'(outq[b + i]), 32'(e));
        end
    endtask

    initial begin
        int qb, s0, d0, r0, l0;
        bus.s_valid         = 1'b0;
        bus.s_data          = 8'h00;
        bus.enc_done_encode = 1'b0;
        bus.enc_en_out      = 1'b0;
        bus.enc_d_out       = 8'h00;
        #3;
        check_quiet("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Straight-through codeword with stray parity strobes during MSG and WAIT.
        qb = outq.size(); s0 = n_start; d0 = n_din; r0 = n_read;
        bus.enc_en_out = 1'b1;
        bus.enc_d_out  = 8'hEE;
        send_msg(MB, 8'h00);
        encode(8'h80);
        wait_idle();
        check_codeword(qb, 8'h00, 8'h80);
        check("start_pulses", 32'(n_start - s0), 32'(1));
        check("din_pulses",   32'(n_din - d0),   32'(MB));
        check("read_pulses",  32'(n_read - r0),  32'(1));

        // Sink ready one cycle in three throughout.
        rdy_mode = 1;
        qb = outq.size(); d0 = n_din;
        send_msg(MB, 8'h00);
        encode(8'h80);
        wait_idle();
        check_codeword(qb, 8'h00, 8'h80);
        check("din_pulses_tog", 32'(n_din - d0), 32'(MB));
        rdy_mode = 0;
        tick();

        // Sink stalled for all of PAR: FIFO must hold every parity byte.
        qb = outq.size();
        send_msg(MB, 8'h20);
        rdy_mode = 2;
        encode(8'hA0);
        check("fifo_full",   32'(dut.u_fifo.full), 32'(1));
        check("stall_count", 32'(outq.size() - qb), 32'(MB));
        check("stall_valid", 32'(bus.m_valid), 32'(1));
        check("stall_busy",  32'(busy), 32'(1));
        rdy_mode = 0;
        wait_idle();
        check_codeword(qb, 8'h20, 8'hA0);
        check("idle_m_valid", 32'(bus.m_valid), 32'(0));

        // Asynchronous reset after 50 message bytes, s_valid held high.
        l0 = n_last;
        send_msg(50, 8'h40);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        bus.s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("partial_no_last", 32'(n_last - l0), 32'(0));
        qb = outq.size();
        send_msg(MB, 8'h10);
        encode(8'h33);
        wait_idle();
        check_codeword(qb, 8'h10, 8'h33);

`ifdef LDPC_FEED_TIMEOUT_EN
        // Encoder never signals done: 64 WAIT cycles then back to IDLE with sticky error.
        r0 = n_read;
        check("err_before", 32'(err_timeout), 32'(0));
        send_msg(MB, 8'h00);
        repeat (63) tick();
        check("err_at_63", 32'(err_timeout), 32'(0));
        check("busy_at_63", 32'(busy), 32'(1));
        tick();
        check("err_at_64", 32'(err_timeout), 32'(1));
        check("busy_at_64", 32'(busy), 32'(0));
        check("tmo_no_read", 32'(n_read - r0), 32'(0));
        repeat (3) tick();
        check("err_sticky", 32'(err_timeout), 32'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ldpc_enc_feeder.md
LDPC_ENC_FEEDER -- requirements
Module: ldpc_enc_feeder

Interface
REQ-001 SHALL have parameter MSG_BYTES, default 128, message bytes per codeword.
REQ-002 SHALL have parameter PAR_BYTES, default 128, parity bytes returned by the encoder per codeword (1024 parity bits).
REQ-003 SHALL have parameter TMO_CYC, default 4096, done_encode timeout in cycles; used only with the macro in REQ-027.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 s_valid / s_ready / s_data  in / out / in  1/1/8  upstream message byte stream.
REQ-007 enc_en_start / enc_en_din / enc_d_in  out  1/1/8  drive the encoder's start, byte strobe and byte.
REQ-008 enc_read_parity  out  1  one-cycle parity read request to the encoder.
REQ-009 enc_done_encode / enc_en_out / enc_d_out  in  1/1/8  encoder done, parity byte strobe, parity byte.
REQ-010 m_valid / m_ready / m_data / m_last  out / in / out / out  1/1/8/1  downstream systematic codeword stream.
REQ-011 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, START, MSG, WAIT, READ, PAR, DRAIN.
REQ-013 IDLE: s_ready=0; s_valid=1 -> START next cycle.
REQ-014 START: enc_en_start=1 for exactly one cycle; -> MSG.
REQ-015 MSG: s_ready=m_ready; m_valid=s_valid; m_data=s_data; on s_valid&&m_ready the byte SHALL be accepted, forwarded downstream and, in the same cycle, presented as enc_d_in with enc_en_din=1.
REQ-016 MSG byte counter SHALL count accepted bytes 0..MSG_BYTES-1; on the MSG_BYTES-th acceptance -> WAIT; counter clears.
REQ-017 WAIT: s_ready=0, m_valid=0; enc_done_encode=1 -> READ.
REQ-018 READ: enc_read_parity=1 for exactly one cycle; -> PAR.
REQ-019 PAR: every cycle with enc_en_out=1 SHALL write enc_d_out into a PAR_BYTES-deep parity FIFO; the encoder has no backpressure, so no parity byte is ever dropped.
REQ-020 The FIFO SHALL drain concurrently: m_valid=!empty, m_data=head; pop on m_valid&&m_ready; simultaneous push and pop in one cycle SHALL keep the occupancy unchanged.
REQ-021 After PAR_BYTES parity writes -> DRAIN; DRAIN -> IDLE on the cycle the final byte pops.
REQ-022 m_last SHALL be 1 only with the final parity byte of a codeword; the codeword is MSG_BYTES+PAR_BYTES bytes.
REQ-023 enc_en_out pulses outside PAR SHALL be ignored; FIFO pointers wrap modulo PAR_BYTES; FIFO overflow cannot occur by construction.
REQ-024 enc_en_din, enc_en_start and enc_read_parity SHALL never be high outside MSG, START and READ respectively.

Reset
REQ-025 On rst_n=0 (any state, mid-codeword included): FSM=IDLE, counters and FIFO pointers=0, s_ready=m_valid=m_last=0, all enc_* outputs=0, enc_d_in=0, m_data=0, busy=0; a partially sent codeword is discarded with no m_last.
REQ-026 After reset release, the first s_valid SHALL start a fresh codeword.

Configuration
REQ-027 Macro LDPC_FEED_TIMEOUT_EN defined: WAIT counts cycles; reaching TMO_CYC without enc_done_encode -> IDLE, and sticky output err_timeout (1 bit) = 1 until reset.
REQ-028 Macro undefined: no timeout counter, no err_timeout port; WAIT waits indefinitely.

Structure
REQ-029 Shared package ldpc_pkg SHALL hold the FSM state enum, the default MSG_BYTES/PAR_BYTES constants and the byte-width constant, shared with the encoder and its control.
REQ-030 The parity FIFO SHALL be a separate sub-module ldpc_par_fifo (synchronous, DEPTH and WIDTH parameters, push/pop/empty/full).

Verification
REQ-031 128 bytes 0x00..0x7F with m_ready=1, encoder model returns 128 parity bytes 0x80..0xFF -> 256 output bytes in order, m_last only on 0xFF, one enc_en_start pulse, 128 enc_en_din pulses.
REQ-032 m_ready toggling 1-of-3 cycles throughout -> s_ready tracks m_ready in MSG, all 128 parity bytes retained, output order unchanged.
REQ-033 m_ready=0 for all of PAR -> FIFO holds 128 bytes (full), no loss; release -> 128 bytes drain, then IDLE.
REQ-034 rst_n pulsed after 50 message bytes -> all outputs 0 asynchronously, next codeword output starts with the first newly sent byte.
REQ-035 With LDPC_FEED_TIMEOUT_EN, TMO_CYC=64, enc_done_encode withheld -> err_timeout=1 at 64 WAIT cycles, FSM IDLE, no enc_read_parity.
REQ-036 Stray enc_en_out during MSG and WAIT -> no FIFO write, output unchanged.
